// File: rtl/ripple_carry_4bit_adder.sv
// Registered 4-bit ripple-carry adder with carry-in, carry-out and signed overflow.
// One pipeline stage: operands qualified by in_valid are captured on the rising clock edge.
module ripple_carry_4bit_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    if (WIDTH != 4) begin : g_bad_width
        $error("ripple_carry_4bit_adder supports WIDTH == 4 only");
    end

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic half;
        assign half         = A[i] ^ B[i];
        assign sum_comb[i]  = half ^ carry[i];
        assign carry[i+1]   = (A[i] & B[i]) | (carry[i] & half);
    end

    // Results hold while in_valid is low; out_valid tracks in_valid every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                S    <= sum_comb;
                cout <= carry[WIDTH];
                ovf  <= carry[WIDTH-1] ^ carry[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_ripple_carry_4bit_adder.sv
// Self-checking bench for ripple_carry_4bit_adder: directed cases, hold, async reset and
// an exhaustive sweep, with expected results queued at drive time and popped at output time.
module tb_ripple_carry_4bit_adder;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       cin;
    logic       in_valid;
    logic [3:0] S;
    logic       cout;
    logic       ovf;
    logic       out_valid;

    typedef struct packed {
        logic [3:0] s;
        logic       c;
        logic       o;
    } result_t;

    result_t sb[$];
    result_t last;
    int      n_checks;
    int      n_errors;

    ripple_carry_4bit_adder #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .in_valid  (in_valid),
        .S         (S),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h (A=%0d B=%0d cin=%0d)", tag, act, exp, A, B, cin);
        end
    endtask

    // Drive one cycle of stimulus, then check the outputs 1 time unit after the capturing edge.
    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic ci,
                        input logic v);
        logic [4:0] sum;
        result_t    e;
        A        = a;
        B        = b;
        cin      = ci;
        in_valid = v;
        if (v) begin
            sum = {1'b0, a} + {1'b0, b} + {4'b0, ci};
            e.s = sum[3:0];
            e.c = sum[4];
            e.o = (a[3] == b[3]) && (sum[3] != a[3]);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        check_eq("out_valid", {7'b0, out_valid}, {7'b0, v});
        if (v) begin
            e = sb.pop_front();
            check_eq("S", {4'b0, S}, {4'b0, e.s});
            check_eq("cout", {7'b0, cout}, {7'b0, e.c});
            check_eq("ovf", {7'b0, ovf}, {7'b0, e.o});
            last = e;
        end else begin
            check_eq("hold_S", {4'b0, S}, {4'b0, last.s});
            check_eq("hold_cout", {7'b0, cout}, {7'b0, last.c});
            check_eq("hold_ovf", {7'b0, ovf}, {7'b0, last.o});
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        last     = '0;
        rst      = 1'b0;
        A        = 4'd0;
        B        = 4'd0;
        cin      = 1'b0;
        in_valid = 1'b0;

        #1 rst = 1'b1;
        #2;
        check_eq("rst_S", {4'b0, S}, 8'd0);
        check_eq("rst_cout", {7'b0, cout}, 8'd0);
        check_eq("rst_ovf", {7'b0, ovf}, 8'd0);
        check_eq("rst_valid", {7'b0, out_valid}, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic add, carry ripple, signed overflow
        step(4'b1000, 4'b0100, 1'b0, 1'b1);
        check_eq("basic_S", {4'b0, S}, 8'd12);
        step(4'b1111, 4'b0000, 1'b1, 1'b1);
        step(4'b1111, 4'b1111, 1'b1, 1'b1);
        check_eq("wrap_S", {4'b0, S}, 8'd15);
        step(4'b0111, 4'b0001, 1'b0, 1'b1);
        check_eq("pos_ovf", {7'b0, ovf}, 8'd1);
        step(4'b1000, 4'b1000, 1'b0, 1'b1);
        check_eq("neg_ovf", {7'b0, ovf}, 8'd1);

        // Hold while in_valid is low
        step(4'd3, 4'd4, 1'b0, 1'b1);
        step(4'd9, 4'd9, 1'b0, 1'b0);
        check_eq("hold_seven", {4'b0, S}, 8'd7);
        step(4'd9, 4'd9, 1'b0, 1'b0);
        step(4'd9, 4'd9, 1'b0, 1'b1);
        check_eq("resume_S", {4'b0, S}, 8'd2);
        check_eq("resume_cout", {7'b0, cout}, 8'd1);

        // Asynchronous reset between clock edges
        step(4'd8, 4'd4, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_S", {4'b0, S}, 8'd0);
        check_eq("async_valid", {7'b0, out_valid}, 8'd0);
        check_eq("async_cout", {7'b0, cout}, 8'd0);
        #1 rst = 1'b0;
        last = '0;
        step(4'd1, 4'd2, 1'b0, 1'b1);

        // Exhaustive sweep, one operation per cycle
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v9;
            v9 = 9'(i);
            step(v9[3:0], v9[7:4], v9[8], 1'b1);
        end
        step(4'd0, 4'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
